// File: rtl/id_ex_reg_if.sv
// -----------------------------------------------------------------------------
// id_ex_reg_if
// Bus between the ID stage and the EX-stage pipeline register.
//   id_*  : decoded instruction fields presented by the ID stage
//   ex_*  : registered copy of those fields as seen by the EX stage
// Modports:
//   master : the ID-stage side (drives id_*, observes ex_*)
//   slave  : the pipeline register (samples id_*, drives ex_*)
// -----------------------------------------------------------------------------
interface id_ex_reg_if;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_imm32;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [3:0]  id_alu_op;
    logic        id_alu_src;
    logic        id_reg_dst;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_mem_to_reg;

    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm32;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src;
    logic        ex_reg_dst;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_mem_to_reg;

    modport master (
        output id_valid, id_pc, id_imm32, id_rs_data, id_rt_data,
               id_rs, id_rt, id_rd, id_alu_op, id_alu_src, id_reg_dst,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
        input  ex_valid, ex_pc, ex_imm32, ex_rs_data, ex_rt_data,
               ex_rs, ex_rt, ex_rd, ex_alu_op, ex_alu_src, ex_reg_dst,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
    );

    modport slave (
        input  id_valid, id_pc, id_imm32, id_rs_data, id_rt_data,
               id_rs, id_rt, id_rd, id_alu_op, id_alu_src, id_reg_dst,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
        output ex_valid, ex_pc, ex_imm32, ex_rs_data, ex_rt_data,
               ex_rs, ex_rt, ex_rd, ex_alu_op, ex_alu_src, ex_reg_dst,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
    );
endinterface

// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
// ID/EX pipeline register with stall, flush/bubble insertion, a saturating
// bubble counter and load-use hazard detection.
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   stall      : hold the EX-stage contents
//   flush      : replace the EX-stage contents with a bubble (beats stall)
//   bus        : id_ex_reg_if.slave, id_* fields in, ex_* fields out
//   bubble_cnt : saturating count of bubbles entering EX
//   load_use   : combinational load-use hazard indication
// -----------------------------------------------------------------------------
module id_ex_reg #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    id_ex_reg_if.slave       bus,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic             load_use
);

    // A load of an invalid ID slot is treated exactly like a flush, so the
    // EX stage never carries stale controls alongside ex_valid=0.
    logic bubble;
    logic load;

    assign bubble = flush | (~stall & ~bus.id_valid);
    assign load   = ~flush & ~stall & bus.id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid      <= 1'b0;
            bus.ex_pc         <= '0;
            bus.ex_imm32      <= '0;
            bus.ex_rs_data    <= '0;
            bus.ex_rt_data    <= '0;
            bus.ex_rs         <= '0;
            bus.ex_rt         <= '0;
            bus.ex_rd         <= '0;
            bus.ex_alu_op     <= '0;
            bus.ex_alu_src    <= 1'b0;
            bus.ex_reg_dst    <= 1'b0;
            bus.ex_reg_write  <= 1'b0;
            bus.ex_mem_read   <= 1'b0;
            bus.ex_mem_write  <= 1'b0;
            bus.ex_mem_to_reg <= 1'b0;
        end else if (bubble) begin
            bus.ex_valid      <= 1'b0;
            bus.ex_pc         <= '0;
            bus.ex_imm32      <= '0;
            bus.ex_rs_data    <= '0;
            bus.ex_rt_data    <= '0;
            bus.ex_rs         <= '0;
            bus.ex_rt         <= '0;
            bus.ex_rd         <= '0;
            bus.ex_alu_op     <= '0;
            bus.ex_alu_src    <= 1'b0;
            bus.ex_reg_dst    <= 1'b0;
            bus.ex_reg_write  <= 1'b0;
            bus.ex_mem_read   <= 1'b0;
            bus.ex_mem_write  <= 1'b0;
            bus.ex_mem_to_reg <= 1'b0;
        end else if (load) begin
            bus.ex_valid      <= 1'b1;
            bus.ex_pc         <= bus.id_pc;
            bus.ex_imm32      <= bus.id_imm32;
            bus.ex_rs_data    <= bus.id_rs_data;
            bus.ex_rt_data    <= bus.id_rt_data;
            bus.ex_rs         <= bus.id_rs;
            bus.ex_rt         <= bus.id_rt;
            bus.ex_rd         <= bus.id_rd;
            bus.ex_alu_op     <= bus.id_alu_op;
            bus.ex_alu_src    <= bus.id_alu_src;
            bus.ex_reg_dst    <= bus.id_reg_dst;
            bus.ex_reg_write  <= bus.id_reg_write;
            bus.ex_mem_read   <= bus.id_mem_read;
            bus.ex_mem_write  <= bus.id_mem_write;
            bus.ex_mem_to_reg <= bus.id_mem_to_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Register $zero never creates a dependency. Reset clears ex_valid
    // asynchronously, which forces this low while rst_n is asserted.
    assign load_use = bus.ex_valid & bus.ex_mem_read & bus.id_valid &
                      (bus.ex_rt != 5'd0) &
                      ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt));

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm32;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } fields_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall;
    logic             flush;
    logic [CNT_W-1:0] bubble_cnt;
    logic             load_use;

    id_ex_reg_if bus();

    id_ex_reg #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .bus        (bus),
        .bubble_cnt (bubble_cnt),
        .load_use   (load_use)
    );

    always #5 clk = ~clk;

    int      errors = 0;
    int      checks = 0;
    bit      cmp_en = 1'b0;
    fields_t m_ex;
    bit      m_valid;
    int      m_cnt;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic fields_t id_fields();
        fields_t f;
        f = '{bus.id_pc, bus.id_imm32, bus.id_rs_data, bus.id_rt_data,
              bus.id_rs, bus.id_rt, bus.id_rd, bus.id_alu_op, bus.id_alu_src,
              bus.id_reg_dst, bus.id_reg_write, bus.id_mem_read,
              bus.id_mem_write, bus.id_mem_to_reg};
        return f;
    endfunction

    function automatic fields_t dut_fields();
        fields_t f;
        f = '{bus.ex_pc, bus.ex_imm32, bus.ex_rs_data, bus.ex_rt_data,
              bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_alu_op, bus.ex_alu_src,
              bus.ex_reg_dst, bus.ex_reg_write, bus.ex_mem_read,
              bus.ex_mem_write, bus.ex_mem_to_reg};
        return f;
    endfunction

    // Reference: flush wins, then stall holds, otherwise the ID slot moves
    // into EX (an empty slot arriving is a bubble).
    task automatic model_update();
        if (flush || (!stall && !bus.id_valid)) begin
            m_ex    = '0;
            m_valid = 1'b0;
            if (m_cnt < SAT) m_cnt++;
        end else if (!stall) begin
            m_ex    = id_fields();
            m_valid = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_ex    = '0;
        m_valid = 1'b0;
        m_cnt   = 0;
    endtask

    function automatic bit exp_load_use();
        return m_valid && m_ex.mem_read && bus.id_valid && (m_ex.rt != 5'd0) &&
               ((m_ex.rt == bus.id_rs) || (m_ex.rt == bus.id_rt));
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst_n) model_update();
        #1;
    endtask

    task automatic rand_inputs();
        bus.id_valid      = ($urandom_range(0, 3) != 0);
        bus.id_pc         = $urandom;
        bus.id_imm32      = $urandom;
        bus.id_rs_data    = $urandom;
        bus.id_rt_data    = $urandom;
        bus.id_rs         = 5'($urandom_range(0, 3));
        bus.id_rt         = 5'($urandom_range(0, 3));
        bus.id_rd         = 5'($urandom);
        bus.id_alu_op     = 4'($urandom);
        bus.id_alu_src    = 1'($urandom);
        bus.id_reg_dst    = 1'($urandom);
        bus.id_reg_write  = 1'($urandom);
        bus.id_mem_read   = 1'($urandom);
        bus.id_mem_write  = 1'($urandom);
        bus.id_mem_to_reg = 1'($urandom);
        stall             = ($urandom_range(0, 3) == 0);
        flush             = ($urandom_range(0, 7) == 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_fields"}, dut_fields(), '0);
        chk({tag, "_valid"}, bus.ex_valid, 1'b0);
        chk({tag, "_cnt"}, bubble_cnt, '0);
        chk({tag, "_load_use"}, load_use, 1'b0);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ex_fields", dut_fields(), m_ex);
            chk("ex_valid", bus.ex_valid, m_valid);
            chk("bubble_cnt", bubble_cnt, m_cnt);
            chk("load_use", load_use, exp_load_use());
        end
    end

    initial begin
        int cnt_before;
        rst_n = 1'b1;
        rand_inputs();
        bus.id_valid = 1'b1;
        bus.id_rs    = 5'd3;
        bus.id_rt    = 5'd3;
        stall        = 1'b0;
        flush        = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_init");
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Load with a sign-extended immediate
        bus.id_valid     = 1'b1;
        bus.id_imm32     = 32'hFFFF8000;
        bus.id_rd        = 5'd9;
        bus.id_reg_write = 1'b1;
        step();
        chk("load_imm32", bus.ex_imm32, 32'hFFFF8000);
        chk("load_rd", bus.ex_rd, 5'd9);
        chk("load_reg_write", bus.ex_reg_write, 1'b1);
        chk("load_valid", bus.ex_valid, 1'b1);

        // Stall holds for three edges, release loads the new value
        bus.id_imm32 = 32'h00001234;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_imm32", bus.ex_imm32, 32'hFFFF8000);
        end
        stall = 1'b0;
        step();
        chk("stall_release_imm32", bus.ex_imm32, 32'h00001234);

        // Flush beats stall and counts a bubble
        cnt_before = int'(bubble_cnt);
        flush = 1'b1;
        stall = 1'b1;
        step();
        chk("flush_stall_valid", bus.ex_valid, 1'b0);
        chk("flush_stall_fields", dut_fields(), '0);
        chk("flush_stall_cnt", bubble_cnt, cnt_before + 1);
        flush = 1'b0;
        stall = 1'b0;

        // Load-use: lw with rt=8 in EX, dependent instruction in ID
        bus.id_valid    = 1'b1;
        bus.id_mem_read = 1'b1;
        bus.id_rt       = 5'd8;
        bus.id_rs       = 5'd1;
        step();
        bus.id_rs       = 5'd8;
        bus.id_rt       = 5'd3;
        bus.id_mem_read = 1'b0;
        #1 chk("load_use_hit", load_use, 1'b1);

        // Async reset in the middle of a stall, with a hazard pending
        stall = 1'b1;
        step();
        chk("pre_reset_load_use", load_use, 1'b1);
        rst_n = 1'b0;
        #1 check_all_zero("reset_mid_stall");
        model_reset();
        #1 rst_n = 1'b1;
        stall = 1'b0;

        // $zero as load destination never hazards
        bus.id_valid    = 1'b1;
        bus.id_mem_read = 1'b1;
        bus.id_rt       = 5'd0;
        step();
        bus.id_rs       = 5'd0;
        bus.id_mem_read = 1'b0;
        #1 chk("load_use_rt0", load_use, 1'b0);

        // Saturation: 20 consecutive empty loads from a clean count
        rst_n = 1'b0;
        #1 model_reset();
        #1 rst_n = 1'b1;
        bus.id_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("sat_cnt", bubble_cnt, (i + 1 > 15) ? 15 : i + 1);
        end
        chk("sat_final", bubble_cnt, 4'hF);

        // Randomized traffic with occasional asynchronous resets
        rst_n = 1'b0;
        #1 model_reset();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            step();
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                #1 check_all_zero("rand_reset");
                model_reset();
                #1 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of bubble counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port stall  input  1  hold EX-stage contents.
REQ-005 SHALL have port flush  input  1  replace EX-stage contents with a bubble.
REQ-006 SHALL have port id_valid  input  1  ID stage holds a real instruction.
REQ-007 SHALL have ports id_pc, id_imm32, id_rs_data, id_rt_data  input  32 each  PC+4, extended immediate from the immediate-extend stage, register-file read data.
REQ-008 SHALL have ports id_rs, id_rt, id_rd  input  5 each  register numbers.
REQ-009 SHALL have ports id_alu_op (4), id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg (1 each)  input  decoded controls.
REQ-010 SHALL have registered outputs ex_valid plus ex_<field> for every id_<field> of REQ-007..009, same widths.
REQ-011 SHALL have port bubble_cnt  output  CNT_W  saturating count of bubbles entering EX.
REQ-012 SHALL have port load_use  output  1  combinational load-use hazard indication.

Function
REQ-013 SHALL evaluate per rising edge, priority: flush > stall > load.
REQ-014 Flush SHALL set ex_valid=0 and every ex_ data, register-number and control output to 0, regardless of stall.
REQ-015 Stall without flush SHALL hold every ex_ output and bubble_cnt unchanged.
REQ-016 Load (no flush, no stall) with id_valid=1 SHALL copy every id_ field to its ex_ output and set ex_valid=1; latency exactly one cycle.
REQ-017 Load with id_valid=0 SHALL behave as flush (REQ-014).
REQ-018 A bubble entering EX (flush, or load with id_valid=0) SHALL increment bubble_cnt by 1 on the same edge.
REQ-019 bubble_cnt SHALL saturate at 2^CNT_W-1; no wrap to 0.
REQ-020 Stall held for N cycles SHALL keep outputs stable for N edges; release loads current id_ values on the next edge.
REQ-021 load_use SHALL equal ex_valid & ex_mem_read & id_valid & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
REQ-022 load_use SHALL be purely combinational from the registered ex_ state and current id_ inputs; no dependence on stall or flush.
REQ-023 ex_imm32 SHALL pass id_imm32 bit-exact; no re-extension or truncation.
REQ-024 No ex_ control output SHALL be nonzero while ex_valid=0.

Reset
REQ-025 rst_n low SHALL immediately, without waiting for clk, force ex_valid=0, every ex_ output to 0 and bubble_cnt to 0.
REQ-026 Reset assertion mid-stall or mid-flush SHALL override both; first edge after rst_n rises SHALL follow REQ-013.
REQ-027 load_use SHALL be 0 while rst_n is low.

Verification
REQ-028 Reset: drive id_ fields nonzero, pulse rst_n low between edges -> all ex_ outputs, bubble_cnt, load_use read 0 before next edge.
REQ-029 Load: id_valid=1, id_imm32=32'hFFFF8000, id_rd=5'd9, id_reg_write=1 -> after one edge ex_imm32=32'hFFFF8000, ex_rd=9, ex_reg_write=1, ex_valid=1.
REQ-030 Stall: after REQ-029 hold stall=1 for 3 edges while id_imm32=32'h00001234 -> ex_imm32 stays 32'hFFFF8000; release -> 32'h00001234 next edge.
REQ-031 Flush+stall same edge with id_valid=1 -> ex_valid=0, all ex_ outputs 0, bubble_cnt increments by 1.
REQ-032 Load-use: ex holds lw with ex_mem_read=1, ex_rt=8; id_rs=8, id_valid=1 -> load_use=1; with ex_rt=0 -> load_use=0.
REQ-033 Saturation: CNT_W=4, drive 20 consecutive id_valid=0 loads -> bubble_cnt reaches 4'hF and stays 4'hF.
